ins_prefetch_q: RTL
===================

Name: ins_prefetch_q

Overview:
Instruction prefetch queue between the instruction ROM and the CPU decode stage. It issues sequential word fetch requests to the ROM, buffers returned instruction words with their addresses in a small FIFO, and presents them to the CPU through a valid/ready handshake. A redirect input (branch or jump) flushes the queue and restarts fetching at a new address, discarding any in-flight ROM response.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16
AW, 16, instruction address width (word addressed)
DW, 16, instruction word width
RESET_PC, 16'h0000, first fetch address after reset

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
rom_req  output  1  one-cycle fetch request pulse to ROM (ROM ready input)
rom_addr  output  AW  fetch address; valid while rom_req=1
rom_dout  input  DW  instruction word from ROM
rom_en_out  input  1  ROM response valid, one-cycle pulse, latency >=1 cycle after rom_req
ins_out  output  DW  head-of-queue instruction
ins_pc  output  AW  address of ins_out
ins_valid  output  1  queue non-empty
ins_ready  input  1  CPU accepts head entry when ins_valid&ins_ready
redirect  input  1  one-cycle pulse: flush and refetch
redirect_pc  input  AW  new fetch address, sampled when redirect=1
q_count  output  clog2(DEPTH)+1  current occupancy (debug)

Behaviour:
- Reset (rst=0, async): state=IDLE, fetch pc=RESET_PC, FIFO empty, rom_req=0, rom_addr=0, ins_valid=0, ins_out=0, ins_pc=0, q_count=0.
- Protocol: at most one outstanding ROM request. All outputs registered.
- FSM states IDLE, WAIT, DROP:
  - IDLE: if redirect=0 and q_count<DEPTH -> rom_req=1 for one cycle, rom_addr=pc, pc<=pc+1 (wraps 2^AW-1 -> 0), go WAIT. If q_count=DEPTH, stay IDLE, rom_req=0.
  - WAIT: on rom_en_out=1 -> push {rom_addr_of_request, rom_dout}, go IDLE. Issue of the next request occurs no earlier than the cycle after the push (min 2-cycle request spacing).
  - DROP: on rom_en_out=1 -> discard data, go IDLE.
- Redirect (highest priority, any state): FIFO cleared (q_count=0, ins_valid=0 next cycle), pc<=redirect_pc; IDLE->IDLE, WAIT->DROP, DROP->DROP. No request is issued in the redirect cycle. Redirect and rom_en_out in the same WAIT cycle: response discarded, go IDLE (no DROP). A pop in the redirect cycle is ignored.
- FIFO: circular, rd/wr pointers wrap at DEPTH. Push and pop in the same cycle: q_count unchanged. ins_ready while ins_valid=0 is ignored. Push never occurs when full, because a request is issued only when q_count<DEPTH and only one is outstanding.
- ins_out/ins_pc show the head entry combinationally from FIFO storage. The head is stable until popped.
- Stray rom_en_out in IDLE: ignored, no push.
- Reset asserted mid-operation: immediate return to reset values; a later ROM response is seen in IDLE and ignored.

Test Plan:
- Reset release, ROM latency 1, ins_ready=1 -> rom_addr sequence 0,1,2,3...; ins_pc/ins_out follow the same order, no drops or duplicates.
- ins_ready=0 held -> exactly 4 requests (addr 0..3), q_count=4, rom_req stays 0. Then pop one -> next request addr 4.
- Redirect to 16'h0100 while in WAIT for addr 2, ROM answers 3 cycles later -> that word not queued, q_count=0, next rom_addr=16'h0100.
- Redirect in the same cycle as rom_en_out -> data dropped; next request at redirect_pc the following cycle after IDLE entry.
- RESET_PC=16'hFFFE -> addresses FFFE, FFFF, 0000, 0001 with correct ins_pc tags.
- Assert rst mid-WAIT, then a late rom_en_out after release -> ignored, fetch restarts at RESET_PC, q_count=0.

Source files
------------

// File: rtl/ins_prefetch_q_if.sv
// Bus bundle for the instruction prefetch queue: ROM fetch side, CPU
// decode side and redirect. The master modport is the prefetch queue.
// The slave modport is the environment, which is the ROM plus the CPU.
interface ins_prefetch_q_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  // ROM fetch port
  logic          rom_req;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_dout;
  logic          rom_en_out;

  // CPU decode port
  logic [DW-1:0] ins_out;
  logic [AW-1:0] ins_pc;
  logic          ins_valid;
  logic          ins_ready;

  // Control flow redirect and debug
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic [CW-1:0] q_count;

  modport master (
    output rom_req, rom_addr, ins_out, ins_pc, ins_valid, q_count,
    input  rom_dout, rom_en_out, ins_ready, redirect, redirect_pc
  );

  modport slave (
    input  rom_req, rom_addr, ins_out, ins_pc, ins_valid, q_count,
    output rom_dout, rom_en_out, ins_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/ins_prefetch_q.sv
// Instruction prefetch queue. It issues one word fetch at a time to the ROM.
// It buffers each returned word together with its address in a circular FIFO.
// It hands the head entry to decode through a valid/ready handshake.
// A redirect flushes the FIFO and restarts fetching at a new address.
// A response that is still in flight at the time of a redirect is discarded.
module ins_prefetch_q #(
  parameter int            DEPTH    = 4,
  parameter int            AW       = 16,
  parameter int            DW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,   // asynchronous, active-low
  ins_prefetch_q_if.master  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic          rom_req_q, rom_req_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] word_mem [DEPTH];
  logic [AW-1:0] pc_mem   [DEPTH];
  logic          push;
  logic          pop;
  logic          not_empty;

  assign not_empty = (count_q != '0);
  assign pop       = not_empty && bus.ins_ready && !bus.redirect;

  // Fetch FSM: issue a request, wait for the reply, or drop a stale reply
  always_comb begin
    // NOTE: every signal written in this block gets a default first, so no latch can be inferred.
    state_d    = state_q;
    pc_d       = pc_q;
    rom_req_d  = 1'b0;
    rom_addr_d = rom_addr_q;
    push       = 1'b0;
    if (bus.redirect) begin
      pc_d = bus.redirect_pc;
      case (state_q)
        // The reply to the outstanding request is still owed. If it lands in
        // this same cycle, it is already consumed and there is nothing left
        // to drop.
        S_WAIT, S_DROP: state_d = bus.rom_en_out ? S_IDLE : S_DROP;
        default:        state_d = S_IDLE;
      endcase
    end else begin
      case (state_q)
        S_IDLE: begin
          if (count_q < CW'(DEPTH)) begin
            rom_req_d  = 1'b1;
            rom_addr_d = pc_q;
            pc_d       = pc_q + AW'(1);
            state_d    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.rom_en_out) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_DROP: begin
          if (bus.rom_en_out) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FIFO bookkeeping: pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control and pointer registers
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    if (!rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      rom_addr_q <= '0;
      rom_req_q  <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rom_addr_q <= rom_addr_d;
      rom_req_q  <= rom_req_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Entry storage, tagged with the address of the request that produced it
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; validity comes from count_q and the head is masked when empty.
    if (push) begin
      word_mem[wr_ptr_q] <= bus.rom_dout;
      pc_mem[wr_ptr_q]   <= rom_addr_q;
    end
  end

  assign bus.rom_req   = rom_req_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.q_count   = count_q;
  assign bus.ins_valid = not_empty;
  assign bus.ins_out   = not_empty ? word_mem[rd_ptr_q] : '0;
  assign bus.ins_pc    = not_empty ? pc_mem[rd_ptr_q]   : '0;
endmodule
